// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Sequences a single-port line-wide BRAM between a 32-bit core port and a line-wide memory port.
module dcache_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned OFFSET_W = 6,
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned LINE_W  = 8 << OFFSET_W,
  localparam int unsigned ENTRY_W = 2 + TAG_W + LINE_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               core_valid,
  output logic               core_ready,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic               core_we,
  input  logic [3:0]         core_wstrb,
  input  logic [31:0]        core_wdata,
  output logic               core_rvalid,
  output logic [31:0]        core_rdata,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               bram_ena,
  output logic               bram_wea,
  output logic [INDEX_W-1:0] bram_addr,
  output logic [ENTRY_W-1:0] bram_din,
  input  logic [ENTRY_W-1:0] bram_dout,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [LINE_W-1:0]  mem_rdata
);

  localparam int WORDS  = int'(LINE_W / 32);
  localparam int WSEL_W = int'(OFFSET_W) - 2;

  typedef enum logic [3:0] {
    StInit, StIdle, StLookup, StWb, StRefill, StFill, StFlRd, StFlChk, StFlWb, StFlInv
  } state_e;

  state_e state_q, state_d;

  logic [INDEX_W-1:0] idx_q;
  logic [TAG_W-1:0]   req_tag_q;
  logic [WSEL_W-1:0]  req_word_q;
  logic               req_we_q;
  logic [3:0]         req_wstrb_q;
  logic [31:0]        req_wdata_q;
  logic [TAG_W-1:0]   vic_tag_q;
  logic [LINE_W-1:0]  vic_data_q;
  logic [LINE_W-1:0]  line_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic               flush_done_q;

  logic               ent_valid, ent_dirty, hit, last_idx, accept;
  logic [TAG_W-1:0]   ent_tag;
  logic [LINE_W-1:0]  ent_data, base_line, merged_line;
  logic [31:0]        word;
  logic               unused_addr;

  assign unused_addr = ^core_addr[1:0];

  assign ent_valid = bram_dout[ENTRY_W-1];
  assign ent_dirty = bram_dout[ENTRY_W-2];
  assign ent_tag   = bram_dout[LINE_W +: TAG_W];
  assign ent_data  = bram_dout[LINE_W-1:0];
  assign hit       = ent_valid && (ent_tag == req_tag_q);
  assign last_idx  = &idx_q;
  assign accept    = core_valid && !flush_req;

  // Same merge serves store hits (BRAM line) and write-allocate fills (refilled line).
  always_comb begin
    base_line   = (state_q == StFill) ? line_q : ent_data;
    merged_line = base_line;
    word        = '0;
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (req_we_q && req_wstrb_q[b] && (req_word_q == WSEL_W'(w))) begin
          merged_line[w*32 + b*8 +: 8] = req_wdata_q[b*8 +: 8];
        end
      end
      if (req_word_q == WSEL_W'(w)) word = merged_line[w*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StInit;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:   if (last_idx) state_d = StIdle;
      StIdle: begin
        if (flush_req)       state_d = StFlRd;
        else if (core_valid) state_d = StLookup;
      end
      StLookup: begin
        if (hit)                         state_d = StIdle;
        else if (ent_valid && ent_dirty) state_d = StWb;
        else                             state_d = StRefill;
      end
      StWb:     if (mem_ack) state_d = StRefill;
      StRefill: if (mem_ack) state_d = StFill;
      StFill:   state_d = StIdle;
      StFlRd:   state_d = StFlChk;
      StFlChk:  state_d = (ent_valid && ent_dirty) ? StFlWb : StFlInv;
      StFlWb:   if (mem_ack) state_d = StFlInv;
      StFlInv:  state_d = last_idx ? StIdle : StFlRd;
      default:  state_d = StInit;
    endcase
  end

  always_comb begin
    core_ready = 1'b0;
    bram_ena   = 1'b0;
    bram_wea   = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      StInit: begin
        // Gated so the BRAM sees no activity while reset is held.
        bram_ena  = rstn;
        bram_wea  = rstn;
        bram_addr = idx_q;
      end
      StIdle: begin
        core_ready = !flush_req;
        if (accept) begin
          bram_ena  = 1'b1;
          bram_addr = core_addr[OFFSET_W +: INDEX_W];
        end
      end
      StLookup: begin
        if (hit && req_we_q) begin
          bram_ena  = 1'b1;
          bram_wea  = 1'b1;
          bram_addr = idx_q;
          bram_din  = {1'b1, 1'b1, req_tag_q, merged_line};
        end
      end
      StWb, StFlWb: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {vic_tag_q, idx_q, {OFFSET_W{1'b0}}};
        mem_wdata = vic_data_q;
      end
      StRefill: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_q, idx_q, {OFFSET_W{1'b0}}};
      end
      StFill: begin
        bram_ena  = 1'b1;
        bram_wea  = 1'b1;
        bram_addr = idx_q;
        bram_din  = {1'b1, req_we_q, req_tag_q, merged_line};
      end
      StFlRd: begin
        bram_ena  = 1'b1;
        bram_addr = idx_q;
      end
      StFlInv: begin
        bram_ena  = 1'b1;
        bram_wea  = 1'b1;
        bram_addr = idx_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q        <= '0;
      req_tag_q    <= '0;
      req_word_q   <= '0;
      req_we_q     <= 1'b0;
      req_wstrb_q  <= '0;
      req_wdata_q  <= '0;
      vic_tag_q    <= '0;
      vic_data_q   <= '0;
      line_q       <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      rvalid_q     <= 1'b0;
      flush_done_q <= 1'b0;
      case (state_q)
        StInit: idx_q <= idx_q + 1'b1;
        StIdle: begin
          if (flush_req) begin
            idx_q <= '0;
          end else if (core_valid) begin
            idx_q       <= core_addr[OFFSET_W +: INDEX_W];
            req_tag_q   <= core_addr[ADDR_W-1 -: TAG_W];
            req_word_q  <= core_addr[OFFSET_W-1:2];
            req_we_q    <= core_we;
            req_wstrb_q <= core_wstrb;
            req_wdata_q <= core_wdata;
          end
        end
        StLookup: begin
          if (hit) begin
            rvalid_q <= 1'b1;
            rdata_q  <= word;
          end else begin
            vic_tag_q  <= ent_tag;
            vic_data_q <= ent_data;
          end
        end
        StRefill: if (mem_ack) line_q <= mem_rdata;
        StFill: begin
          rvalid_q <= 1'b1;
          rdata_q  <= word;
        end
        StFlChk: begin
          vic_tag_q  <= ent_tag;
          vic_data_q <= ent_data;
        end
        StFlInv: begin
          idx_q <= idx_q + 1'b1;
          if (last_idx) flush_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign flush_done  = flush_done_q;

endmodule
